// File: rtl/mem_pkg.sv
// Shared defaults and width helpers for the interleaved byte FIFO.
package mem_pkg;

    localparam int unsigned LANES_DEF       = 32'd8;
    localparam int unsigned DEPTH_BYTES_DEF = 32'd256;

    // Bits needed to name one byte lane.
    function automatic int unsigned lane_width(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

    // Bits needed to address one row of a bank.
    function automatic int unsigned row_width(input int unsigned depth_bytes, input int unsigned lanes);
        return $clog2(depth_bytes / lanes);
    endfunction

    // Request length field: must hold the value LANES itself.
    function automatic int unsigned len_width(input int unsigned lanes);
        return $clog2(lanes) + 32'd1;
    endfunction

    // Fill level field: must hold the value DEPTH_BYTES itself.
    function automatic int unsigned level_width(input int unsigned depth_bytes);
        return $clog2(depth_bytes) + 32'd1;
    endfunction

    // A request length is legal when it moves between 1 and LANES bytes.
    function automatic logic len_legal(input int unsigned len, input int unsigned lanes);
        return (len >= 32'd1) && (len <= lanes);
    endfunction

endpackage

// File: rtl/fifo_byte_bank.sv
// One byte-wide bank of the interleaved FIFO: simple dual-port RAM with a
// registered (synchronous) read port. Contents are deliberately not reset;
// the FIFO level hides whatever the array holds after reset.
module fifo_byte_bank
    import mem_pkg::*;
#(
    parameter int unsigned ROWS  = DEPTH_BYTES_DEF / LANES_DEF,
    parameter int unsigned ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic             re,
    input  logic [ROW_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem_r [ROWS];
    logic [7:0] rdata_r;

    // Write port: store one byte when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: capture the addressed byte; hold it otherwise.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/interleaved_fifo.sv
// Byte-granular FIFO built from LANES byte banks. Stream byte a lives in bank
// a%LANES at row a/LANES, so any 1..LANES consecutive bytes touch each bank at
// most once and can be moved in a single cycle.
module interleaved_fifo
    import mem_pkg::*;
#(
    parameter int unsigned LANES       = LANES_DEF,
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 wr_valid,
    input  logic [len_width(LANES)-1:0]          wr_len,
    input  logic [LANES*8-1:0]                   wr_data,
    output logic                                 wr_ready,
    input  logic                                 rd_req,
    input  logic [len_width(LANES)-1:0]          rd_len,
    output logic                                 rd_ready,
    output logic                                 rd_valid,
    output logic [LANES*8-1:0]                   rd_data,
    output logic [level_width(DEPTH_BYTES)-1:0]  level,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 len_err
);

    localparam int unsigned LANE_W = lane_width(LANES);
    localparam int unsigned ROWS   = DEPTH_BYTES / LANES;
    localparam int unsigned ROW_W  = row_width(DEPTH_BYTES, LANES);
    localparam int unsigned PTR_W  = $clog2(DEPTH_BYTES);
    localparam int unsigned LEN_W  = len_width(LANES);
    localparam int unsigned LVL_W  = level_width(DEPTH_BYTES);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH_BYTES);

    // Pointers are byte addresses; their natural wrap is the modulo-depth wrap.
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [LVL_W-1:0]   level_r, level_nxt_s, free_s;
    logic               full_r, empty_r;
    logic               wr_len_ok_s, rd_len_ok_s, wr_ready_s, rd_ready_s;
    logic               wr_acc_s, rd_acc_s;
    logic [LANE_W-1:0]  wr_lo_s, rd_lo_s, rd_lo_r, rot_idx_s;
    logic [ROW_W-1:0]   wr_row_s, rd_row_s;
    logic [LANES-1:0]   rd_mask_s, rd_mask_r;
    logic               rd_valid_r, len_err_r;
    logic [LANES*8-1:0] bank_q_s, rd_data_s;

    // Length legality, space/level handshakes and the accept decisions.
    always_comb begin
        wr_len_ok_s = len_legal(32'(wr_len), LANES);
        rd_len_ok_s = len_legal(32'(rd_len), LANES);
        free_s      = DEPTH_LVL - level_r;
        wr_ready_s  = (free_s >= LVL_W'(wr_len));
        rd_ready_s  = (level_r >= LVL_W'(rd_len));
        wr_acc_s    = wr_valid && wr_ready_s && wr_len_ok_s && !flush;
        rd_acc_s    = rd_req && rd_ready_s && rd_len_ok_s && !flush;
        wr_lo_s     = wr_ptr_r[LANE_W-1:0];
        wr_row_s    = wr_ptr_r[PTR_W-1:LANE_W];
        rd_lo_s     = rd_ptr_r[LANE_W-1:0];
        rd_row_s    = rd_ptr_r[PTR_W-1:LANE_W];
    end

    // Next pointers and level; flush overrides any same-cycle transfer.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        if (flush) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            level_nxt_s  = '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(wr_len);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(rd_len);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            level_nxt_s = level_r
                        + (wr_acc_s ? LVL_W'(wr_len) : {LVL_W{1'b0}})
                        - (rd_acc_s ? LVL_W'(rd_len) : {LVL_W{1'b0}});
        end
    end

    // Pointer, level and status flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            full_r   <= (level_nxt_s == DEPTH_LVL);
            empty_r  <= (level_nxt_s == {LVL_W{1'b0}});
        end
    end

    // Lanes below the accepted read length carry data; the rest read as zero.
    always_comb begin
        rd_mask_s = '0;
        for (int j = 0; j < LANES; j++) begin
            rd_mask_s[j] = (LEN_W'(j) < rd_len);
        end
    end

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        localparam logic [LANE_W-1:0] BANK = LANE_W'(b);
        logic [LANE_W-1:0] wk_s;
        logic              we_s;
        logic [7:0]        wbyte_s;
        logic [ROW_W-1:0]  wrow_s, rrow_s;

        // Map this bank to its write byte index and the row for each port;
        // banks below the start lane belong to the following row.
        always_comb begin
            wk_s    = BANK - wr_lo_s;
            we_s    = wr_acc_s && ({1'b0, wk_s} < wr_len);
            wbyte_s = wr_data[{wk_s, 3'b000} +: 8];
            wrow_s  = (BANK < wr_lo_s) ? (wr_row_s + ROW_W'(1)) : wr_row_s;
            rrow_s  = (BANK < rd_lo_s) ? (rd_row_s + ROW_W'(1)) : rd_row_s;
        end

        fifo_byte_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .we    (we_s),
            .waddr (wrow_s),
            .wdata (wbyte_s),
            .re    (rd_acc_s),
            .raddr (rrow_s),
            .rdata (bank_q_s[8*b +: 8])
        );
    end

    // Read-side pipeline: valid pulse, start lane and lane mask of the read
    // accepted last cycle, plus the length-error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_lo_r    <= '0;
            rd_mask_r  <= '0;
            len_err_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            len_err_r  <= (wr_valid && !wr_len_ok_s) || (rd_req && !rd_len_ok_s);
            if (rd_acc_s) begin
                rd_lo_r   <= rd_lo_s;
                rd_mask_r <= rd_mask_s;
            end else begin
                rd_lo_r   <= rd_lo_r;
                rd_mask_r <= '0;
            end
        end
    end

    // Rotate bank outputs so the oldest byte lands in lane 0.
    always_comb begin
        rd_data_s = '0;
        rot_idx_s = '0;
        for (int j = 0; j < LANES; j++) begin
            rot_idx_s = rd_lo_r + LANE_W'(j);
            if (rd_mask_r[j]) begin
                rd_data_s[8*j +: 8] = bank_q_s[{rot_idx_s, 3'b000} +: 8];
            end else begin
                rd_data_s[8*j +: 8] = 8'h00;
            end
        end
    end

    assign wr_ready = wr_ready_s;
    assign rd_ready = rd_ready_s;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_s;
    assign level    = level_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign len_err  = len_err_r;

endmodule

// File: tb/tb_interleaved_fifo.sv
// Scoreboard bench for interleaved_fifo: a byte-queue reference model predicts
// handshakes, level and read data; a monitor matches DUT read/len_err pulses.
module tb_interleaved_fifo;

    localparam int LANES = 8;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset, flush, wr_valid, rd_req;
    logic [3:0]  wr_len, rd_len;
    logic [63:0] wr_data;
    logic        wr_ready, rd_ready, rd_valid, full, empty, len_err;
    logic [63:0] rd_data;
    logic [8:0]  level;

    interleaved_fifo #(.LANES(LANES), .DEPTH_BYTES(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_len(wr_len), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_len(rd_len), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .level(level), .full(full), .empty(empty), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rd_exp_t;

    logic [7:0] model_q[$];
    rd_exp_t    rd_q[$];
    int         len_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int pick_len();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 0;
        if (r == 1) return 9;
        return 1 + (r % 8);
    endfunction

    // Drive one cycle of stimulus from a negedge, predict, and check status.
    task automatic step(input logic wv, input int wl, input logic [63:0] wd,
                        input logic rv, input int rl, input logic fl);
        logic        w_rdy, r_rdy, w_acc, r_acc, w_ok, r_ok;
        logic [63:0] exp_data;
        wr_valid = wv; wr_len = 4'(wl); wr_data = wd;
        rd_req = rv; rd_len = 4'(rl); flush = fl;
        #1;
        w_rdy = (DEPTH - model_q.size()) >= wl;
        r_rdy = model_q.size() >= rl;
        chk("wr_ready", 64'(wr_ready), 64'(w_rdy));
        chk("rd_ready", 64'(rd_ready), 64'(r_rdy));
        w_ok  = (wl >= 1) && (wl <= LANES);
        r_ok  = (rl >= 1) && (rl <= LANES);
        w_acc = wv && w_rdy && w_ok && !fl;
        r_acc = rv && r_rdy && r_ok && !fl;
        if ((wv && !w_ok) || (rv && !r_ok)) len_q.push_back(cyc + 1);
        if (fl) begin
            model_q.delete();
        end else begin
            if (r_acc) begin
                exp_data = 64'd0;
                for (int i = 0; i < rl; i++) exp_data[8*i +: 8] = model_q.pop_front();
                rd_q.push_back('{cyc + 1, exp_data});
            end
            if (w_acc) begin
                for (int i = 0; i < wl; i++) model_q.push_back(wd[8*i +: 8]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("level", 64'(level), 64'(model_q.size()));
        chk("full",  64'(full),  64'(model_q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(model_q.size() == 0));
    endtask

    task automatic idle();
        step(1'b0, 1, 64'd0, 1'b0, 1, 1'b0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: match every rd_valid / len_err pulse against the scoreboard.
    always @(negedge clk) begin
        rd_exp_t e;
        if (reset) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rd_data", rd_data, e.data);
                end
            end
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                void'(rd_q.pop_front());
                chk("rd_valid_missing", 64'(rd_valid), 64'd1);
            end
            if (len_err) begin
                if (len_q.size() == 0) begin
                    chk("len_err_unexpected", 64'(len_err), 64'd0);
                end else begin
                    chk("len_err_cycle", 64'(cyc), 64'(len_q.pop_front()));
                end
            end
            while (len_q.size() > 0 && len_q[0] < cyc) begin
                void'(len_q.pop_front());
                chk("len_err_missing", 64'(len_err), 64'd1);
            end
        end
    end

    initial begin
        logic wv, rv, fl;
        int   wl, rl, pw;
        reset = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        wr_len = 4'd1; rd_len = 4'd1; wr_data = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_level",    64'(level),    64'd0);
        chk("rst_empty",    64'(empty),    64'd1);
        chk("rst_full",     64'(full),     64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data",  rd_data,       64'd0);
        chk("rst_len_err",  64'(len_err),  64'd0);
        reset = 1'b1;
        idle();

        // 3-byte write then 3-byte read
        step(1'b1, 3, 64'h1122_3344_55CC_BBAA, 1'b0, 1, 1'b0);
        step(1'b0, 1, 64'd0, 1'b1, 3, 1'b0);
        idle();

        // Write spanning a row boundary, read back in stream order
        step(1'b0, 1, 64'd0, 1'b0, 1, 1'b1);
        step(1'b1, 5, rnd64(), 1'b0, 1, 1'b0);
        step(1'b1, 8, 64'h0706_0504_0302_0100, 1'b0, 1, 1'b0);
        step(1'b0, 1, 64'd0, 1'b1, 5, 1'b0);
        step(1'b0, 1, 64'd0, 1'b1, 8, 1'b0);
        idle();

        // Fill to capacity, then a rejected 1-byte write
        step(1'b0, 1, 64'd0, 1'b0, 1, 1'b1);
        for (int i = 0; i < DEPTH / LANES; i++) step(1'b1, 8, rnd64(), 1'b0, 1, 1'b0);
        step(1'b1, 1, rnd64(), 1'b0, 1, 1'b0);
        idle();

        // Simultaneous write 8 / read 4 at level 4
        step(1'b0, 1, 64'd0, 1'b0, 1, 1'b1);
        step(1'b1, 4, rnd64(), 1'b0, 1, 1'b0);
        step(1'b1, 8, rnd64(), 1'b1, 4, 1'b0);
        idle();

        // Illegal lengths
        step(1'b1, 0, rnd64(), 1'b0, 1, 1'b0);
        idle();
        step(1'b0, 1, 64'd0, 1'b1, 9, 1'b0);
        idle();

        // Flush with a write at level 20; later data must not include it
        step(1'b0, 1, 64'd0, 1'b0, 1, 1'b1);
        step(1'b1, 8, rnd64(), 1'b0, 1, 1'b0);
        step(1'b1, 8, rnd64(), 1'b0, 1, 1'b0);
        step(1'b1, 4, rnd64(), 1'b0, 1, 1'b0);
        step(1'b1, 8, rnd64(), 1'b0, 1, 1'b1);
        step(1'b1, 4, rnd64(), 1'b0, 1, 1'b0);
        step(1'b0, 1, 64'd0, 1'b1, 4, 1'b0);
        idle();

        // Read in flight across a flush; read dropped by a same-cycle flush
        step(1'b1, 6, rnd64(), 1'b0, 1, 1'b0);
        step(1'b0, 1, 64'd0, 1'b1, 2, 1'b0);
        step(1'b0, 1, 64'd0, 1'b0, 1, 1'b1);
        step(1'b1, 8, rnd64(), 1'b0, 1, 1'b0);
        step(1'b0, 1, 64'd0, 1'b1, 4, 1'b1);
        idle();

        // Reset asserted while a read is being requested
        step(1'b1, 8, rnd64(), 1'b0, 1, 1'b0);
        idle();
        rd_req = 1'b1; rd_len = 4'd2;
        #1 reset = 1'b0;
        model_q.delete();
        @(posedge clk); #1;
        chk("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_mid_level",    64'(level),    64'd0);
        chk("rst_mid_rd_data",  rd_data,       64'd0);
        @(negedge clk);
        rd_req = 1'b0; reset = 1'b1;
        idle();

        // Randomized traffic with alternating write-heavy / read-heavy phases
        for (int n = 0; n < 1500; n++) begin
            pw = (((n / 150) % 2) == 0) ? 80 : 25;
            wv = ($urandom_range(0, 99) < pw);
            rv = ($urandom_range(0, 99) < (100 - pw));
            wl = pick_len();
            rl = pick_len();
            fl = ($urandom_range(0, 99) == 0);
            if (fl) begin
                wl = $urandom_range(1, LANES);
                rl = $urandom_range(1, LANES);
            end
            step(wv, wl, rnd64(), rv, rl, fl);
        end

        repeat (3) idle();
        chk("rd_q_drained",  64'(rd_q.size()),  64'd0);
        chk("len_q_drained", 64'(len_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interleaved_fifo.md
INTERLEAVED_FIFO -- requirements
Module: interleaved_fifo

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning byte lanes per entry; power of 2, >=2.
REQ-002 SHALL have parameter DEPTH_BYTES, default 256, meaning total byte capacity; power of 2, multiple of LANES.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of the FIFO contents.
REQ-006 SHALL have port wr_valid, input, 1, write request.
REQ-007 SHALL have port wr_len, input, $clog2(LANES)+1, number of bytes to write (1..LANES).
REQ-008 SHALL have port wr_data, input, LANES*8, write bytes; byte k is bits [8k+7:8k] and is written in order k=0 first.
REQ-009 SHALL have port wr_ready, output, 1, high when free space >= wr_len.
REQ-010 SHALL have port rd_req, input, 1, read request.
REQ-011 SHALL have port rd_len, input, $clog2(LANES)+1, number of bytes to read (1..LANES).
REQ-012 SHALL have port rd_ready, output, 1, high when level >= rd_len.
REQ-013 SHALL have port rd_valid, output, 1, one-cycle pulse marking rd_data valid.
REQ-014 SHALL have port rd_data, output, LANES*8, read bytes, oldest byte in lane 0; lanes >= rd_len are zero.
REQ-015 SHALL have port level, output, $clog2(DEPTH_BYTES)+1, bytes stored.
REQ-016 SHALL have ports full and empty, output, 1 each; full when level==DEPTH_BYTES, empty when level==0.
REQ-017 SHALL have port len_err, output, 1, one-cycle pulse on a request with length 0 or >LANES.

Function
REQ-018 SHALL accept a write when wr_valid && wr_ready && 1<=wr_len<=LANES; wr_ptr SHALL advance by wr_len.
REQ-019 SHALL accept a read when rd_req && rd_ready && 1<=rd_len<=LANES; rd_ptr SHALL advance by rd_len.
REQ-020 SHALL store the stream byte at address a in bank a%LANES, at row a/LANES; a write spanning the row boundary SHALL put lower-indexed lanes at row+1.
REQ-021 SHALL return read data with 1-cycle latency: rd_valid and rd_data appear in the cycle after acceptance.
REQ-022 SHALL rotate bank outputs so the byte at rd_ptr lands in lane 0, using the rd_ptr registered at acceptance.
REQ-023 SHALL update level by +wr_len -rd_len on simultaneous accepted write and read; wr_ready and rd_ready SHALL use the pre-update level.
REQ-024 SHALL make a byte readable no earlier than the cycle after its write is accepted.
REQ-025 SHALL wrap pointers modulo DEPTH_BYTES, with no gap bytes.
REQ-026 SHALL ignore, with no state change, a write while !wr_ready or a read while !rd_ready.
REQ-027 SHALL ignore an illegal-length request and raise len_err for one cycle.
REQ-028 SHALL make flush take priority over same-cycle reads and writes: pointers and level go to 0, and an in-flight rd_valid is still delivered next cycle.

Reset
REQ-029 SHALL, on reset low, asynchronously set wr_ptr, rd_ptr and level to 0, rd_valid and len_err to 0, and rd_data to 0; empty SHALL be 1 and full SHALL be 0.
REQ-030 SHALL not clear bank contents on reset; the contents are unobservable because level is 0.
REQ-031 SHALL, when reset is asserted mid-read, leave rd_valid low on the following cycle.

Structure
REQ-032 SHALL place the defaults for LANES and DEPTH_BYTES and the derived widths (lane index, row address, length, level) in the shared mem_pkg.
REQ-033 SHALL use one sub-module, fifo_byte_bank: a simple dual-port RAM of DEPTH_BYTES/LANES bytes with synchronous read, instantiated LANES times.

Verification
REQ-034 SHALL cover reset then wr_len=3, wr_data=0x..CCBBAA, then rd_len=3 -> next cycle rd_valid=1, rd_data[23:0]=0xCCBBAA, upper lanes 0, level 3->0, empty=1.
REQ-035 SHALL cover write 5 bytes, then write 8 bytes 0x00..07 across the row boundary, then read 5 and read 8 -> second read returns 0x07060504_03020100 in stream order.
REQ-036 SHALL cover filling to 256 bytes -> full=1 and wr_ready=0 for wr_len=1; a further write leaves level at 256.
REQ-037 SHALL cover level=4 with simultaneous wr_len=8 and rd_len=4 -> level=8 and the read returns the original 4 bytes.
REQ-038 SHALL cover wr_len=0 and, separately, rd_len=9 -> len_err pulses once each and level is unchanged.
REQ-039 SHALL cover flush asserted together with wr_valid at level=20 -> level=0 and empty=1 next cycle, and the write is discarded.
